// File: rtl/hazard_stall_unit.sv
// Operand-side issue control for the non-forwarding RV32I pipeline: tracks in-flight
// destination registers and holds the ID instruction until its sources are written back.
module hazard_stall_unit #(
   parameter int HAZ_DEPTH = 3,
   parameter int CNT_W     = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             id_valid_i,
   input  logic [4:0]       id_rs1_addr_i,
   input  logic [4:0]       id_rs2_addr_i,
   input  logic             id_rs1_used_i,
   input  logic             id_rs2_used_i,
   input  logic [4:0]       id_rd_addr_i,
   input  logic             id_rd_wren_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             bubble_o,
   output logic [31:0]      busy_mask_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   // Scoreboard: index k is the stage k+1 after ID (0 = EX ... HAZ_DEPTH-1 = WB).
   logic [HAZ_DEPTH-1:0] vld_p;
   logic [4:0]           rd_p [HAZ_DEPTH];

   logic        rs1_match;
   logic        rs2_match;
   logic        rs1_hit;
   logic        rs2_hit;
   logic        stall;
   logic        ent0_vld;
   logic [31:0] busy_mask;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Hazard detection against every tracked stage, WB included: the register file
   // write in WB is not visible to a same-cycle ID read.
   always_comb begin
      rs1_match = 1'b0;
      rs2_match = 1'b0;
      busy_mask = '0;
      for (int k = 0; k < HAZ_DEPTH; k++) begin
         if (vld_p[k]) begin
            busy_mask[rd_p[k]] = 1'b1;
            if (rd_p[k] == id_rs1_addr_i) begin
               rs1_match = 1'b1;
            end
            if (rd_p[k] == id_rs2_addr_i) begin
               rs2_match = 1'b1;
            end
         end
      end
      busy_mask[0] = 1'b0;
   end

   assign rs1_hit  = id_rs1_used_i & (id_rs1_addr_i != 5'd0) & rs1_match;
   assign rs2_hit  = id_rs2_used_i & (id_rs2_addr_i != 5'd0) & rs2_match;
   assign stall    = id_valid_i & ~flush_i & (rs1_hit | rs2_hit);
   assign ent0_vld = id_valid_i & id_rd_wren_i & (id_rd_addr_i != 5'd0) & ~stall & ~flush_i;

   assign stall_o     = stall;
   assign bubble_o    = stall | flush_i;
   assign busy_mask_o = busy_mask;

   // Stage boundary: ID -> EX entry, then shift toward WB; the WB entry falls off.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_p       <= '0;
         stall_cnt_o <= '0;
      end else begin
         vld_p[0] <= ent0_vld;
         for (int k = 1; k < HAZ_DEPTH; k++) begin
            vld_p[k] <= vld_p[k-1];
         end
         if (stall) begin
            stall_cnt_o <= sat_inc(stall_cnt_o);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      rd_p[0] <= id_rd_addr_i;
      for (int k = 1; k < HAZ_DEPTH; k++) begin
         rd_p[k] <= rd_p[k-1];
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: expected outputs are queued per step and
// compared against the combinational outputs sampled just after inputs settle.
module tb_hazard_stall_unit;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             id_valid;
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic             rs1_used;
   logic             rs2_used;
   logic [4:0]       rd;
   logic             rd_wren;
   logic             flush;
   logic             stall;
   logic             bubble;
   logic [31:0]      busy_mask;
   logic [CNT_W-1:0] stall_cnt;

   typedef struct {
      string            tag;
      logic             stall;
      logic             bubble;
      logic [31:0]      mask;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   hazard_stall_unit #(.HAZ_DEPTH(3), .CNT_W(CNT_W)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .id_valid_i    (id_valid),
      .id_rs1_addr_i (rs1),
      .id_rs2_addr_i (rs2),
      .id_rs1_used_i (rs1_used),
      .id_rs2_used_i (rs2_used),
      .id_rd_addr_i  (rd),
      .id_rd_wren_i  (rd_wren),
      .flush_i       (flush),
      .stall_o       (stall),
      .bubble_o      (bubble),
      .busy_mask_o   (busy_mask),
      .stall_cnt_o   (stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push_exp(input string tag, input logic s, input logic b,
                           input logic [31:0] m, input int c);
      exp_t e;
      e.tag    = tag;
      e.stall  = s;
      e.bubble = b;
      e.mask   = m;
      e.cnt    = CNT_W'(c);
      exp_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL scoreboard_empty observed=0 entries required=1 entry");
      end else begin
         e = exp_q.pop_front();
         checks++;
         assert (stall === e.stall) else begin
            failures++;
            $error("FAIL %s stall observed=%0b expected=%0b", e.tag, stall, e.stall);
         end
         checks++;
         assert (bubble === e.bubble) else begin
            failures++;
            $error("FAIL %s bubble observed=%0b expected=%0b", e.tag, bubble, e.bubble);
         end
         checks++;
         assert (busy_mask === e.mask) else begin
            failures++;
            $error("FAIL %s busy_mask observed=%h expected=%h", e.tag, busy_mask, e.mask);
         end
         checks++;
         assert (stall_cnt === e.cnt) else begin
            failures++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt, e.cnt);
         end
      end
   endtask

   task automatic step(input string tag,
                       input logic v, input logic [4:0] a1, input logic u1,
                       input logic [4:0] a2, input logic u2,
                       input logic [4:0] d, input logic w, input logic fl,
                       input logic s, input logic b, input logic [31:0] m, input int c);
      @(negedge clk);
      id_valid = v;
      rs1      = a1;
      rs1_used = u1;
      rs2      = a2;
      rs2_used = u2;
      rd       = d;
      rd_wren  = w;
      flush    = fl;
      push_exp(tag, s, b, m, c);
      check_out();
   endtask

   function automatic int sat(input int n);
      return (n > 15) ? 15 : n;
   endfunction

   initial begin
      int stalls;
      rst_n = 1'b0;
      id_valid = 1'b0; rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
      rd = '0; rd_wren = 1'b0; flush = 1'b0;

      // reset and idle
      step("rst_idle",      0, 0,0, 0,0, 0,0, 0,  0,0, 32'h0, 0);
      rst_n = 1'b1;
      step("post_rst_idle", 0, 0,0, 0,0, 0,0, 0,  0,0, 32'h0, 0);

      // add x5,x1,x2 ; sub x6,x5,x3
      step("raw_add",    1, 1,1, 2,1, 5,1, 0,  0,0, 32'h0,  0);
      step("raw_stall1", 1, 5,1, 3,1, 6,1, 0,  1,1, 32'h20, 0);
      step("raw_stall2", 1, 5,1, 3,1, 6,1, 0,  1,1, 32'h20, 1);
      step("raw_stall3", 1, 5,1, 3,1, 6,1, 0,  1,1, 32'h20, 2);
      step("raw_issue",  1, 5,1, 3,1, 6,1, 0,  0,0, 32'h0,  3);
      step("raw_drain1", 0, 0,0, 0,0, 0,0, 0,  0,0, 32'h40, 3);
      step("raw_drain2", 0, 0,0, 0,0, 0,0, 0,  0,0, 32'h40, 3);
      step("raw_drain3", 0, 0,0, 0,0, 0,0, 0,  0,0, 32'h40, 3);

      // addi x7 ; independent x8 ; reader of x7
      step("gap_addi",   1, 1,1, 0,0, 7,1, 0,  0,0, 32'h0,   3);
      step("gap_indep",  1, 2,1, 3,1, 8,1, 0,  0,0, 32'h80,  3);
      step("gap_stall1", 1, 7,1, 0,0, 9,1, 0,  1,1, 32'h180, 3);
      step("gap_stall2", 1, 7,1, 0,0, 9,1, 0,  1,1, 32'h180, 4);
      step("gap_issue",  1, 7,1, 0,0, 9,1, 0,  0,0, 32'h100, 5);
      step("gap_drain1", 0, 0,0, 0,0, 0,0, 0,  0,0, 32'h200, 5);
      step("gap_drain2", 0, 0,0, 0,0, 0,0, 0,  0,0, 32'h200, 5);
      step("gap_drain3", 0, 0,0, 0,0, 0,0, 0,  0,0, 32'h200, 5);

      // x0 neither creates nor matches a hazard
      step("x0_write",   1, 1,1, 0,0, 0,1, 0,  0,0, 32'h0, 5);
      step("x0_read",    1, 0,1, 0,1, 0,0, 0,  0,0, 32'h0, 5);

      // unused rs2 field equal to a busy register, then a real rs2 reader
      step("rs2u_write", 1, 1,1, 0,0, 7,1, 0,  0,0, 32'h0,  5);
      step("rs2u_nouse", 1, 1,1, 7,0, 0,0, 0,  0,0, 32'h80, 5);
      step("rs2_stall",  1, 1,1, 7,1, 11,1, 0, 1,1, 32'h80, 5);

      // flush wins over the pending hazard; the would-be x11 entry is killed
      step("flush_hz",   1, 1,1, 7,1, 11,1, 1, 0,1, 32'h80, 6);
      step("flush_after",0, 0,0, 0,0, 0,0, 0,  0,0, 32'h0,  6);

      // asynchronous reset between edges while stalled
      step("ar_write",   1, 1,1, 0,0, 12,1, 0, 0,0, 32'h0,    6);
      step("ar_stall",   1, 12,1, 0,0, 13,1, 0, 1,1, 32'h1000, 6);
      #2;
      rst_n = 1'b0;
      push_exp("ar_async", 0, 0, 32'h0, 0);
      check_out();
      @(negedge clk);
      id_valid = 1'b0;
      rst_n    = 1'b1;
      step("ar_release", 0, 0,0, 0,0, 0,0, 0,  0,0, 32'h0, 0);

      // 21 forced stall cycles into a 4-bit counter
      stalls = 0;
      for (int i = 0; i < 7; i++) begin
         step("sat_write", 1, 1,1, 0,0, 13,1, 0, 0,0, 32'h0, sat(stalls));
         for (int j = 0; j < 3; j++) begin
            step("sat_stall", 1, 13,1, 0,0, 0,0, 0, 1,1, 32'h2000, sat(stalls));
            stalls++;
         end
         step("sat_issue", 1, 13,1, 0,0, 0,0, 0, 0,0, 32'h0, sat(stalls));
      end
      step("sat_hold", 0, 0,0, 0,0, 0,0, 0, 0,0, 32'h0, 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
